// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundle of every handshake/bus signal around the shared physical-memory
//   access port.
//   - IFU side : if_req_valid/if_req_ready/if_addr, if_rsp_valid/if_rdata
//   - LSU side : ls_req_valid/ls_req_ready/ls_addr/ls_wen/ls_wdata/ls_wmask,
//                ls_rsp_valid/ls_rdata
//   - Memory   : mem_req_valid/mem_req_ready/mem_addr/mem_wen/mem_wdata/
//                mem_wmask, mem_rsp_valid/mem_rdata
//   Modports:
//   - master : the arbiter, which masters the memory port and serves the
//              requesters
//   - slave  : the surroundings, meaning the requesters plus the memory wrapper
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int MASK_W = 8
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req_valid;
    logic              ls_req_ready;
    logic [ADDR_W-1:0] ls_addr;
    logic              ls_wen;
    logic [DATA_W-1:0] ls_wdata;
    logic [MASK_W-1:0] ls_wmask;
    logic              ls_rsp_valid;
    logic [DATA_W-1:0] ls_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  if_req_valid, if_addr,
        output if_req_ready, if_rsp_valid, if_rdata,
        input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        output ls_req_ready, ls_rsp_valid, ls_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        output if_req_valid, if_addr,
        input  if_req_ready, if_rsp_valid, if_rdata,
        output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        input  ls_req_ready, ls_rsp_valid, ls_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single physical-memory access port between instruction fetch
//   (IFU) and load/store (LSU). Exactly one transaction is outstanding at a
//   time, and each response is routed back to the requester that owns it.
//   When both requesters ask in the same cycle, round-robin arbitration
//   grants the one that did not win last time.
//   Ports:
//   - clk   : system clock, rising edge
//   - rst_n : asynchronous active-low reset
//   - bus   : mem_port_arbiter_if.master, carrying the IFU/LSU request and
//             response channels plus the memory request/response channel
//   Flow: IDLE (arbitrate, latch) -> REQ (present to memory) -> WAIT
//   (route response) -> IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int MASK_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.master   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Owner and last-grant encoding: 0 = IFU, 1 = LSU.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    state_t            state_q;
    logic              owner_q;
    logic              last_grant_q;
    logic              mem_req_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;

    logic              grant_if_s;
    logic              grant_ls_s;
    logic              rsp_if_s;
    logic              rsp_ls_s;

    // Combinational round-robin grant. Requests are considered only in IDLE,
    // and a tie goes to the requester that did not win the previous grant.
    always_comb begin
        grant_if_s = 1'b0;
        grant_ls_s = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.if_req_valid && bus.ls_req_valid) begin
                if (last_grant_q == OWN_IF) begin
                    grant_ls_s = 1'b1;
                end else begin
                    grant_if_s = 1'b1;
                end
            end else if (bus.if_req_valid) begin
                grant_if_s = 1'b1;
            end else if (bus.ls_req_valid) begin
                grant_ls_s = 1'b1;
            end else begin
                grant_if_s = 1'b0;
                grant_ls_s = 1'b0;
            end
        end else begin
            grant_if_s = 1'b0;
            grant_ls_s = 1'b0;
        end
    end

    // Response routing. A memory response counts only while waiting for one,
    // so a response that arrives in IDLE or REQ is dropped.
    always_comb begin
        rsp_if_s = 1'b0;
        rsp_ls_s = 1'b0;
        if ((state_q == ST_WAIT) && bus.mem_rsp_valid) begin
            rsp_if_s = (owner_q == OWN_IF);
            rsp_ls_s = (owner_q == OWN_LS);
        end else begin
            rsp_if_s = 1'b0;
            rsp_ls_s = 1'b0;
        end
    end

    // Transaction sequencer. Request fields are latched on accept, and
    // mem_req_valid is registered so that it rises the cycle after the accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            owner_q         <= OWN_IF;
            last_grant_q    <= OWN_IF;
            mem_req_valid_q <= 1'b0;
            addr_q          <= {ADDR_W{1'b0}};
            wen_q           <= 1'b0;
            wdata_q         <= {DATA_W{1'b0}};
            wmask_q         <= {MASK_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_if_s) begin
                        // Fetches are reads, so the write fields are forced to zero.
                        addr_q          <= bus.if_addr;
                        wen_q           <= 1'b0;
                        wdata_q         <= {DATA_W{1'b0}};
                        wmask_q         <= {MASK_W{1'b0}};
                        owner_q         <= OWN_IF;
                        last_grant_q    <= OWN_IF;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= ST_REQ;
                    end else if (grant_ls_s) begin
                        addr_q          <= bus.ls_addr;
                        wen_q           <= bus.ls_wen;
                        wdata_q         <= bus.ls_wdata;
                        wmask_q         <= bus.ls_wmask;
                        owner_q         <= OWN_LS;
                        last_grant_q    <= OWN_LS;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= ST_REQ;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= ST_WAIT;
                    end else begin
                        state_q <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                default: begin
                    mem_req_valid_q <= 1'b0;
                    state_q         <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.if_req_ready  = grant_if_s;
    assign bus.ls_req_ready  = grant_ls_s;

    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wmask     = wmask_q;

    assign bus.if_rsp_valid  = rsp_if_s;
    assign bus.ls_rsp_valid  = rsp_ls_s;

    // Read data goes only to the owner. The other requester sees zero.
    assign bus.if_rdata = ((state_q == ST_WAIT) && (owner_q == OWN_IF)) ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.ls_rdata = ((state_q == ST_WAIT) && (owner_q == OWN_LS)) ? bus.mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Inputs are driven 1 ns after the
//   rising edge, and outputs are checked 1 ns later, well away from any edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int MASK_W = 8;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " if_req_ready"},  64'(bus.if_req_ready),  64'd0);
        check_eq({tag, " ls_req_ready"},  64'(bus.ls_req_ready),  64'd0);
        check_eq({tag, " mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
        check_eq({tag, " mem_addr"},      bus.mem_addr,           64'd0);
        check_eq({tag, " mem_wen"},       64'(bus.mem_wen),       64'd0);
        check_eq({tag, " mem_wdata"},     bus.mem_wdata,          64'd0);
        check_eq({tag, " mem_wmask"},     64'(bus.mem_wmask),     64'd0);
        check_eq({tag, " if_rsp_valid"},  64'(bus.if_rsp_valid),  64'd0);
        check_eq({tag, " ls_rsp_valid"},  64'(bus.ls_rsp_valid),  64'd0);
        check_eq({tag, " if_rdata"},      bus.if_rdata,           64'd0);
        check_eq({tag, " ls_rdata"},      bus.ls_rdata,           64'd0);
    endtask

    // Runs one full transaction, starting from IDLE at posedge+1 with the
    // requester inputs already driven. The transaction takes 3+stalls cycles:
    // accept, REQ (with the stall cycles), then the response cycle.
    task automatic do_txn(input string tag, input bit is_ls, input logic [63:0] addr,
                          input bit wen, input logic [63:0] wdata, input logic [7:0] wmask,
                          input logic [63:0] rdata, input int stalls, input bit spur);
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        #1;
        check_eq({tag, " acc if_req_ready"},  64'(bus.if_req_ready),  64'(!is_ls));
        check_eq({tag, " acc ls_req_ready"},  64'(bus.ls_req_ready),  64'(is_ls));
        check_eq({tag, " acc mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
        next_cycle();
        for (int i = 0; i <= stalls; i++) begin
            bus.mem_req_ready = (i == stalls) ? 1'b1 : 1'b0;
            bus.mem_rsp_valid = (i == stalls) ? 1'b0 : spur;
            bus.mem_rdata     = 64'hBAD0_BAD0_BAD0_BAD0;
            #1;
            check_eq({tag, " req mem_req_valid"}, 64'(bus.mem_req_valid), 64'd1);
            check_eq({tag, " req mem_addr"},      bus.mem_addr,           addr);
            check_eq({tag, " req mem_wen"},       64'(bus.mem_wen),       64'(wen));
            check_eq({tag, " req mem_wdata"},     bus.mem_wdata,          wdata);
            check_eq({tag, " req mem_wmask"},     64'(bus.mem_wmask),     64'(wmask));
            check_eq({tag, " req if_rsp_valid"},  64'(bus.if_rsp_valid),  64'd0);
            check_eq({tag, " req ls_rsp_valid"},  64'(bus.ls_rsp_valid),  64'd0);
            check_eq({tag, " req readies"},       64'({bus.if_req_ready, bus.ls_req_ready}), 64'd0);
            next_cycle();
        end
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = rdata;
        #1;
        check_eq({tag, " rsp if_rsp_valid"},  64'(bus.if_rsp_valid),  64'(!is_ls));
        check_eq({tag, " rsp ls_rsp_valid"},  64'(bus.ls_rsp_valid),  64'(is_ls));
        check_eq({tag, " rsp if_rdata"},      bus.if_rdata,           is_ls ? 64'd0 : rdata);
        check_eq({tag, " rsp ls_rdata"},      bus.ls_rdata,           is_ls ? rdata : 64'd0);
        check_eq({tag, " rsp mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
        check_eq({tag, " rsp readies"},       64'({bus.if_req_ready, bus.ls_req_ready}), 64'd0);
        next_cycle();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = 64'd0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.if_req_valid  = 1'b0;
        bus.if_addr       = 64'd0;
        bus.ls_req_valid  = 1'b0;
        bus.ls_addr       = 64'd0;
        bus.ls_wen        = 1'b0;
        bus.ls_wdata      = 64'd0;
        bus.ls_wmask      = 8'd0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = 64'd0;

        // Reset state
        next_cycle();
        next_cycle();
        #1;
        check_all_zero("reset");
        next_cycle();
        rst_n = 1'b1;

        // First fetch after reset
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 64'h8000_0000;
        do_txn("fetch0", 1'b0, 64'h8000_0000, 1'b0, 64'd0, 8'd0, 64'h0000_0413, 0, 1'b0);
        bus.if_req_valid = 1'b0;
        #1;
        check_eq("fetch0 back to idle mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        next_cycle();

        // Both requesters valid: the grants should run LS, IF, LS, IF
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 64'h8000_0004;
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 64'h8000_1000;
        bus.ls_wen       = 1'b0;
        bus.ls_wdata     = 64'd0;
        bus.ls_wmask     = 8'd0;
        for (int k = 0; k < 4; k++) begin
            if ((k % 2) == 0) begin
                do_txn("rr ls", 1'b1, 64'h8000_1000, 1'b0, 64'd0, 8'd0, 64'h1111_0000 + 64'(k), 0, 1'b0);
            end else begin
                do_txn("rr if", 1'b0, 64'h8000_0004, 1'b0, 64'd0, 8'd0, 64'h2222_0000 + 64'(k), 0, 1'b0);
            end
        end
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;

        // Spurious response while IDLE: no pulse, and still idle next cycle
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 64'h5555_5555;
        #1;
        check_eq("idle spur if_rsp_valid", 64'(bus.if_rsp_valid), 64'd0);
        check_eq("idle spur ls_rsp_valid", 64'(bus.ls_rsp_valid), 64'd0);
        check_eq("idle spur ls_rdata",     bus.ls_rdata,          64'd0);
        next_cycle();
        bus.mem_rsp_valid = 1'b0;
        #1;
        check_eq("idle spur mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        next_cycle();

        // LSU write with 3 stall cycles and spurious responses while in REQ
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 64'h8000_2000;
        bus.ls_wen       = 1'b1;
        bus.ls_wdata     = 64'hDEAD_BEEF;
        bus.ls_wmask     = 8'h0F;
        do_txn("wr", 1'b1, 64'h8000_2000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 64'd0, 3, 1'b1);
        bus.ls_req_valid = 1'b0;
        bus.ls_wen       = 1'b0;

        // Reset while waiting on an LSU read
        bus.ls_req_valid  = 1'b1;
        bus.ls_addr       = 64'h8000_3000;
        bus.ls_wdata      = 64'd0;
        bus.ls_wmask      = 8'd0;
        bus.mem_req_ready = 1'b0;
        #1;
        check_eq("rst ls accept", 64'(bus.ls_req_ready), 64'd1);
        next_cycle();
        bus.ls_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        #1;
        check_eq("rst req mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
        next_cycle();
        bus.mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst mid-wait");
        next_cycle();
        rst_n = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 64'h7777_7777;
        #1;
        check_eq("rst late ls_rsp_valid", 64'(bus.ls_rsp_valid), 64'd0);
        check_eq("rst late if_rsp_valid", 64'(bus.if_rsp_valid), 64'd0);
        check_eq("rst late ls_rdata",     bus.ls_rdata,          64'd0);
        check_eq("rst late mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        next_cycle();
        bus.mem_rsp_valid = 1'b0;

        // Back-to-back fetches only: one accept every 3 cycles, and the LSU is never granted
        bus.if_req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.if_addr = 64'h8000_0100 + 64'(4 * k);
            do_txn("b2b", 1'b0, 64'h8000_0100 + 64'(4 * k), 1'b0, 64'd0, 8'd0, 64'h0000_0013 + 64'(k), 0, 1'b0);
        end
        bus.if_req_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the single physical-memory access port (the DPI pmem read/write path).
- Shares the port between instruction fetch (IFU) and load/store (LSU) with valid/ready handshakes.
- Keeps exactly one transaction outstanding and routes each response back to its owner.
- Sits between IFU/LSU and the memory-access wrapper; round-robin fairness prevents fetch or data starvation.

Parameters:
ADDR_W, 64, address width (CPU_WIDTH)
DATA_W, 64, data width (CPU_WIDTH)
MASK_W, 8, write byte-mask width (DATA_W/8)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
if_req_valid  in  1  IFU read request
if_req_ready  out  1  IFU request accepted this cycle
if_addr  in  ADDR_W  IFU fetch address (pc)
if_rsp_valid  out  1  IFU response pulse
if_rdata  out  DATA_W  IFU read data (inst in low 32 bits)
ls_req_valid  in  1  LSU request
ls_req_ready  out  1  LSU request accepted this cycle
ls_addr  in  ADDR_W  LSU address
ls_wen  in  1  1=write, 0=read
ls_wdata  in  DATA_W  LSU write data
ls_wmask  in  MASK_W  LSU byte mask
ls_rsp_valid  out  1  LSU response pulse (read data or write ack)
ls_rdata  out  DATA_W  LSU read data
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  latched address
mem_wen  out  1  latched write enable (0 for IFU)
mem_wdata  out  DATA_W  latched write data
mem_wmask  out  MASK_W  latched mask (0 for IFU)
mem_rsp_valid  in  1  memory response / write ack
mem_rdata  in  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, REQ, WAIT. State, owner, last_grant and the request latches are flops cleared by rst_n low.
- Reset values: state=IDLE, owner=IF, last_grant=IF, latched addr/wdata/wmask/wen=0.
  - Consequence: every output is 0 during and after reset until the first accept.
- IDLE, arbitration:
  - Only one valid requester: grant it.
  - Both valid: grant the one not equal to last_grant.
  - Grant is combinational: the granted req_ready=1, the other req_ready=0.
  - On accept: latch addr/wen/wdata/wmask (IFU forces wen=0, wmask=0), set owner and last_grant, go to REQ.
  - No valid requester: remain in IDLE.
- REQ: mem_req_valid=1 with the latched fields.
  - mem_req_ready=1 moves to WAIT.
  - Latched fields stay stable until accepted.
- WAIT: wait for mem_rsp_valid (unbounded).
  - Routing: if_rsp_valid = (state==WAIT & owner==IF & mem_rsp_valid); ls_rsp_valid likewise for owner==LS.
  - if_rdata and ls_rdata pass mem_rdata through combinationally. The non-owner data output is 0.
  - Responses are single-cycle pulses. The FSM returns to IDLE on the response cycle.
- req_ready is 0 in REQ and WAIT; new requests are not accepted until IDLE.
- mem_rsp_valid outside WAIT is ignored: no response pulse, no state change.
- Minimum latency: accept at cycle N, mem_req_valid at N+1, response at N+2 (zero-wait memory), next accept at N+3.
- Writes behave exactly like reads; ls_rsp_valid is the write ack and ls_rdata is don't-care.
- Requesters must hold valid/fields stable until ready. The arbiter samples fields only on the accept cycle.
- rst_n asserted mid-transaction: the transaction is abandoned and the FSM returns to IDLE immediately. No response is generated after reset release. A late mem_rsp_valid is ignored because the FSM is in IDLE.
- last_grant updates only on an accept, not on a response.

Test Plan:
- Reset release, if_req_valid=1, if_addr=0x80000000, mem_req_ready=1, mem_rsp_valid the next cycle with rdata=0x00000413 -> if_req_ready at cycle 0; mem_req_valid at cycle 1 with mem_addr=0x80000000 and mem_wen=0; if_rsp_valid=1 at cycle 2 with if_rdata=0x413.
- Both valid continuously (IFU 0x80000004, LSU read 0x80001000) -> grant order LS, IF, LS, IF (first tie goes to LS since last_grant resets to IF); mem_addr alternates; each response goes only to the matching owner.
- LSU write addr=0x80002000, wdata=0xDEADBEEF, wmask=0x0F, mem_req_ready held 0 for 3 cycles -> mem_req_valid held 4 cycles with stable fields; ls_rsp_valid pulses on the ack; if_rsp_valid stays 0.
- Spurious mem_rsp_valid=1 in IDLE and in REQ -> no rsp pulse and no state change.
- rst_n low for 1 cycle while in WAIT (owner=LS), then mem_rsp_valid=1 after release -> all outputs 0; ls_rsp_valid never asserts; next IFU request is accepted normally.
- Only IFU requesting back-to-back with a zero-wait memory -> one accept every 3 cycles; ls_req_ready stays 0.
